// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the MIPS pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Default register-address width for the 32-entry MIPS register file.
    localparam int REG_AW_DEF = 5;

    // Architectural $zero; a load targeting it never creates a dependency.
    localparam int REG_ZERO = 0;

    // Bubble counter width; LOAD_BUBBLES is limited to 1..15.
    localparam int BCNT_W = 4;

    // Controller state: RUN, or inside a multi-bubble load-use stall.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } hz_state_e;

    // Bubbles still owed after the first one, which is issued from RUN.
    function automatic logic [BCNT_W-1:0] extra_bubbles(input int load_bubbles);
        return BCNT_W'(load_bubbles - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: W-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; inc is sampled every cycle.
//
// Ports:
//   clk    - clock
//   reset  - synchronous active-high clear
//   inc    - count this cycle
//   count  - current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturate: once all-ones, further increments are dropped.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Purpose: load-use stall, memory-wait freeze and taken-branch flush control for the 5-stage MIPS pipe.
// Latency: control outputs are combinational (same cycle); counters update one cycle later.
// Backpressure: dmem wait freezes the whole pipe and overrides branch and stall handling.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   if_id_rs/rt, uses_rs/rt     - source fields of the ID instruction and whether each is read
//   id_ex_rt, id_ex_mem_read    - destination of the EX instruction and whether it is a load
//   ex_mem_mem_access, dmem_ready - MEM-stage access and data-memory completion
//   branch_taken_ex             - branch/jump resolved taken in EX
//   pc_write, if_id_write       - front-end load enables
//   id_ex_bubble                - inject NOP into ID/EX
//   if_id_flush, id_ex_flush    - clear wrong-path instructions
//   pipe_freeze                 - hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles, freeze_cycles, flush_count - saturating performance counters
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rs,
    input  logic              if_id_uses_rt,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic              id_ex_mem_read,
    input  logic              ex_mem_mem_access,
    input  logic              dmem_ready,
    input  logic              branch_taken_ex,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  freeze_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [BCNT_W-1:0] bcnt_q;
    logic [BCNT_W-1:0] bcnt_d;

    logic src_rs_match;
    logic src_rt_match;
    logic dst_nonzero;
    logic hz;
    logic mw;

    // Only source fields the instruction actually reads can create a
    // dependency, and a load into $zero produces nothing to wait for.
    assign src_rs_match = if_id_uses_rs && (if_id_rs == id_ex_rt);
    assign src_rt_match = if_id_uses_rt && (if_id_rt == id_ex_rt);
    assign dst_nonzero  = (id_ex_rt != REG_AW'(REG_ZERO));
    assign hz           = id_ex_mem_read && (src_rs_match || src_rt_match) && dst_nonzero;

    // MEM stage is waiting on data memory.
    assign mw = ex_mem_mem_access && !dmem_ready;

    // Priority: reset > freeze > branch flush > load-use bubble.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = state_q;
        bcnt_d       = bcnt_q;

        if (reset) begin
            // Outputs stay at their defaults so nothing stalls or flushes
            // while the pipe is being reset.
            state_d = ST_RUN;
            bcnt_d  = '0;
        end else if (mw) begin
            // Whole pipe holds, including the stall bookkeeping. A taken
            // branch seen now is re-presented by EX once the freeze lifts.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (branch_taken_ex) begin
            // The stalled ID instruction is on the wrong path, so any
            // bubbles still owed are pointless.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            bcnt_d      = '0;
        end else if (state_q == ST_LU_STALL) begin
            // Keep bubbling until the load result is reachable, whatever hz
            // says now (the load has already left EX).
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            bcnt_d       = bcnt_q - BCNT_W'(1);
            if (bcnt_q == BCNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end else if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_BUBBLES > 1) begin
                state_d = ST_LU_STALL;
                bcnt_d  = extra_bubbles(LOAD_BUBBLES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (id_ex_bubble),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pipe_freeze),
        .count (freeze_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: self-checking bench for hazard_control_unit across three builds.
// Latency: controls sampled 1 time unit after the input change; counters one edge later.
// Backpressure: memory-wait freezes are driven directly on the inputs.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       if_id_uses_rs, if_id_uses_rt, id_ex_mem_read;
    logic       ex_mem_mem_access, dmem_ready, branch_taken_ex;

    logic pc_write [3];
    logic if_id_write [3];
    logic id_ex_bubble [3];
    logic if_id_flush [3];
    logic id_ex_flush [3];
    logic pipe_freeze [3];

    logic [31:0] st0, fr0, fl0, st1, fr1, fl1;
    logic [1:0]  st2, fr2, fl2;

    always #5 clk = ~clk;

    // Instance 0: LOAD_BUBBLES=1; instance 1: LOAD_BUBBLES=3; instance 2: LOAD_BUBBLES=2, CNT_W=2.
    hazard_control_unit #(.REG_AW(5), .LOAD_BUBBLES(1), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt), .id_ex_rt(id_ex_rt),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_access(ex_mem_mem_access),
        .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write[0]), .if_id_write(if_id_write[0]), .id_ex_bubble(id_ex_bubble[0]),
        .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .pipe_freeze(pipe_freeze[0]),
        .stall_cycles(st0), .freeze_cycles(fr0), .flush_count(fl0));

    hazard_control_unit #(.REG_AW(5), .LOAD_BUBBLES(3), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt), .id_ex_rt(id_ex_rt),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_access(ex_mem_mem_access),
        .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write[1]), .if_id_write(if_id_write[1]), .id_ex_bubble(id_ex_bubble[1]),
        .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .pipe_freeze(pipe_freeze[1]),
        .stall_cycles(st1), .freeze_cycles(fr1), .flush_count(fl1));

    hazard_control_unit #(.REG_AW(5), .LOAD_BUBBLES(2), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt), .id_ex_rt(id_ex_rt),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_access(ex_mem_mem_access),
        .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write[2]), .if_id_write(if_id_write[2]), .id_ex_bubble(id_ex_bubble[2]),
        .if_id_flush(if_id_flush[2]), .id_ex_flush(id_ex_flush[2]), .pipe_freeze(pipe_freeze[2]),
        .stall_cycles(st2), .freeze_cycles(fr2), .flush_count(fl2));

    // Observed controls packed as {pc_write, if_id_write, bubble, if_flush, id_flush, freeze}.
    logic [5:0]  dut_ctl [3];
    logic [63:0] dut_st [3];
    logic [63:0] dut_fr [3];
    logic [63:0] dut_fl [3];

    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign dut_ctl[g] = {pc_write[g], if_id_write[g], id_ex_bubble[g],
                             if_id_flush[g], id_ex_flush[g], pipe_freeze[g]};
    end
    assign dut_st[0] = {32'b0, st0}; assign dut_fr[0] = {32'b0, fr0}; assign dut_fl[0] = {32'b0, fl0};
    assign dut_st[1] = {32'b0, st1}; assign dut_fr[1] = {32'b0, fr1}; assign dut_fl[1] = {32'b0, fl1};
    assign dut_st[2] = {62'b0, st2}; assign dut_fr[2] = {62'b0, fr2}; assign dut_fl[2] = {62'b0, fl2};

    // Reference model: bubbles still owed per instance, plus integer counters.
    int     lb [3]   = '{1, 3, 2};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 3};
    int     owed [3];
    longint m_st [3], m_fr [3], m_fl [3];
    logic [5:0] exp_ctl [3];
    longint exp_st [3], exp_fr [3], exp_fl [3];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_BUBBLE = 6'b001000;
    localparam logic [5:0] C_FLUSH  = 6'b110110;
    localparam logic [5:0] C_FREEZE = 6'b000001;

    function automatic longint sat_inc(input longint v, input longint mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    // Predict this cycle's controls and the counter values visible now
    // (before the coming edge), then advance the model across the edge.
    task automatic model_step();
        bit hz, mw;
        hz = id_ex_mem_read && (id_ex_rt != 0) &&
             ((if_id_uses_rs && if_id_rs == id_ex_rt) || (if_id_uses_rt && if_id_rt == id_ex_rt));
        mw = ex_mem_mem_access && !dmem_ready;
        for (int k = 0; k < 3; k++) begin
            exp_st[k] = m_st[k]; exp_fr[k] = m_fr[k]; exp_fl[k] = m_fl[k];
            if (reset) begin
                exp_ctl[k] = C_RUN; owed[k] = 0;
                m_st[k] = 0; m_fr[k] = 0; m_fl[k] = 0;
            end else if (mw) begin
                exp_ctl[k] = C_FREEZE; m_fr[k] = sat_inc(m_fr[k], cmax[k]);
            end else if (branch_taken_ex) begin
                exp_ctl[k] = C_FLUSH; owed[k] = 0; m_fl[k] = sat_inc(m_fl[k], cmax[k]);
            end else if (owed[k] > 0) begin
                exp_ctl[k] = C_BUBBLE; owed[k]--; m_st[k] = sat_inc(m_st[k], cmax[k]);
            end else if (hz) begin
                exp_ctl[k] = C_BUBBLE; owed[k] = lb[k] - 1; m_st[k] = sat_inc(m_st[k], cmax[k]);
            end else begin
                exp_ctl[k] = C_RUN;
            end
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then predict.
    task automatic cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] ert,
                         input logic mr, input logic acc, input logic rdy, input logic br);
        @(negedge clk);
        reset = r; if_id_rs = rs; if_id_rt = rt; if_id_uses_rs = urs; if_id_uses_rt = urt;
        id_ex_rt = ert; id_ex_mem_read = mr; ex_mem_mem_access = acc; dmem_ready = rdy;
        branch_taken_ex = br;
        #1;
        model_step();
    endtask

    task automatic idle();
        cycle(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    endtask

    task automatic hazard_rs8();
        cycle(0, 5'd8, 5'd2, 1, 1, 5'd8, 1, 0, 1, 0);
    endtask

    task automatic test_reset();
        // Reset with every hazard/freeze/branch input active: controls still default.
        cycle(1, 5'd8, 5'd8, 1, 1, 5'd8, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl[k] !== C_RUN) begin
                n_fail++; $display("FAIL reset_ctl u%0d: got %b want %b", k, dut_ctl[k], C_RUN);
            end
        end
        cycle(1, 5'd8, 5'd8, 1, 1, 5'd8, 1, 1, 0, 1);
        idle();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({dut_ctl[k], dut_st[k], dut_fr[k], dut_fl[k]} !== {C_RUN, 192'd0}) begin
                n_fail++;
                $display("FAIL reset_state u%0d: ctl %b cnt %0d/%0d/%0d want 110000 0/0/0",
                         k, dut_ctl[k], dut_st[k], dut_fr[k], dut_fl[k]);
            end
        end
    endtask

    // Shared per-cycle comparison against the model, written inline per test.
    task automatic test_load_use();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) hazard_rs8(); else idle();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_ctl[k] !== exp_ctl[k] || dut_st[k] !== 64'(exp_st[k])) begin
                    n_fail++;
                    $display("FAIL load_use u%0d c%0d: ctl %b stall %0d want %b %0d",
                             k, c, dut_ctl[k], dut_st[k], exp_ctl[k], exp_st[k]);
                end
            end
        end
        n_chk++;
        if (st0 !== 32'd1 || st1 !== 32'd3 || st2 !== 2'd2) begin
            n_fail++; $display("FAIL load_use_counts: got %0d/%0d/%0d want 1/3/2", st0, st1, st2);
        end
    endtask

    task automatic test_no_stall();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 5'd0, 5'd4, 1, 0, 5'd0, 1, 0, 1, 0);   // load into $zero, ID reads rs=0
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl[k] !== C_RUN) begin
                n_fail++; $display("FAIL zero_reg u%0d: got %b want %b", k, dut_ctl[k], C_RUN);
            end
        end
        cycle(0, 5'd3, 5'd9, 1, 0, 5'd9, 1, 0, 1, 0);   // rt matches but is not read
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl[k] !== C_RUN) begin
                n_fail++; $display("FAIL unused_rt u%0d: got %b want %b", k, dut_ctl[k], C_RUN);
            end
        end
        idle();
        n_chk++;
        if (st0 !== 0 || st1 !== 0 || st2 !== 0) begin
            n_fail++; $display("FAIL no_stall_counts: got %0d/%0d/%0d want 0/0/0", st0, st1, st2);
        end
    endtask

    task automatic test_branch_abort();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        hazard_rs8();
        cycle(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);   // taken branch in 2nd bubble slot
        n_chk++;
        if (dut_ctl[1] !== C_FLUSH) begin
            n_fail++; $display("FAIL branch_abort_ctl: got %b want %b", dut_ctl[1], C_FLUSH);
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_ctl[k] !== exp_ctl[k]) begin
                    n_fail++; $display("FAIL branch_after u%0d c%0d: got %b want %b",
                                       k, c, dut_ctl[k], exp_ctl[k]);
                end
            end
        end
        n_chk++;
        if (fl1 !== 32'd1 || st1 !== 32'd1) begin
            n_fail++; $display("FAIL branch_counts: flush %0d stall %0d want 1 1", fl1, st1);
        end
    endtask

    task automatic test_freeze_in_stall();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        hazard_rs8();
        for (int c = 0; c < 8; c++) begin
            // Freeze for 4 cycles while ID still shows the hazard, then drain.
            if (c < 4) cycle(0, 5'd8, 5'd2, 1, 0, 5'd8, 1, 1, 0, 0);
            else idle();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_ctl[k] !== exp_ctl[k] || dut_fr[k] !== 64'(exp_fr[k])) begin
                    n_fail++;
                    $display("FAIL freeze u%0d c%0d: ctl %b frz %0d want %b %0d",
                             k, c, dut_ctl[k], dut_fr[k], exp_ctl[k], exp_fr[k]);
                end
            end
        end
        n_chk++;
        if (fr1 !== 32'd4 || st1 !== 32'd3) begin
            n_fail++; $display("FAIL freeze_counts: freeze %0d stall %0d want 4 3", fr1, st1);
        end
    endtask

    task automatic test_reset_mid_stall();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        hazard_rs8();
        cycle(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle();
        n_chk++;
        if (pc_write[1] !== 1'b1 || st1 !== 0 || fr1 !== 0 || fl1 !== 0) begin
            n_fail++; $display("FAIL reset_mid_stall: pc_write %b cnt %0d/%0d/%0d want 1 0/0/0",
                               pc_write[1], st1, fr1, fl1);
        end
    endtask

    task automatic test_saturation();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) cycle(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
        idle();
        n_chk++;
        if (fr2 !== 2'd3 || fr0 !== 32'd5) begin
            n_fail++; $display("FAIL saturation: narrow %0d wide %0d want 3 5", fr2, fr0);
        end
    endtask

    task automatic test_random();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_ctl[k] !== exp_ctl[k] || dut_st[k] !== 64'(exp_st[k]) ||
                    dut_fr[k] !== 64'(exp_fr[k]) || dut_fl[k] !== 64'(exp_fl[k])) begin
                    n_fail++;
                    $display("FAIL random u%0d c%0d: ctl %b cnt %0d/%0d/%0d want %b %0d/%0d/%0d",
                             k, c, dut_ctl[k], dut_st[k], dut_fr[k], dut_fl[k],
                             exp_ctl[k], exp_st[k], exp_fr[k], exp_fl[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            owed[k] = 0; m_st[k] = 0; m_fr[k] = 0; m_fl[k] = 0;
        end
        reset = 1'b1; if_id_rs = '0; if_id_rt = '0; if_id_uses_rs = 1'b0; if_id_uses_rt = 1'b0;
        id_ex_rt = '0; id_ex_mem_read = 1'b0; ex_mem_mem_access = 1'b0; dmem_ready = 1'b1;
        branch_taken_ex = 1'b0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_abort();
        test_freeze_in_stall();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
